vip_gray_binary_bbox: RTL

//   Consumes the median-filtered 8-bit gray stream: binarizes each pixel against a threshold and

---
 rtl/vip_gray_binary_bbox.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/vip_gray_binary_bbox.sv
// Binarizes the median-filtered gray stream and tracks the per-frame
// foreground bounding box and pixel count, published at frame end.
module vip_gray_binary_bbox #(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter bit          FG_DARK = 1'b1,
    parameter int unsigned CNT_W   = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pe_frame_vsync,
    input  logic             pe_frame_href,
    input  logic             pe_frame_clken,
    input  logic [7:0]       pe_img,
    input  logic [7:0]       threshold,
    output logic             pos_frame_vsync,
    output logic             pos_frame_href,
    output logic             pos_frame_clken,
    output logic [7:0]       pos_img,
    output logic             frame_done,
    output logic             bbox_valid,
    output logic [9:0]       x_min,
    output logic [9:0]       x_max,
    output logic [9:0]       y_min,
    output logic [9:0]       y_max,
    output logic [CNT_W-1:0] fg_count
);

    localparam logic [9:0]       XSat   = 10'(IMG_W - 1);
    localparam logic [9:0]       YSat   = 10'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CntSat = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

    state_e           state_q, state_d;
    logic             vsync_q, href_q;
    logic [7:0]       thr_q, thr_d, thr_eff;
    logic [9:0]       x_q, x_d, y_q, y_d, px, py;
    logic [9:0]       xmin_q, xmin_d, xmax_q, xmax_d;
    logic [9:0]       ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vsync_rise, vsync_fall, href_fall;
    logic             pix, fg, publish;

    always_comb begin
        vsync_rise = pe_frame_vsync & ~vsync_q;
        vsync_fall = ~pe_frame_vsync & vsync_q;
        href_fall  = ~pe_frame_href & href_q;
        pix        = pe_frame_clken & pe_frame_href;

        // A pixel arriving with the vsync edge already belongs to the new frame.
        thr_d   = vsync_rise ? threshold : thr_q;
        thr_eff = thr_d;
        fg      = FG_DARK ? (pe_img < thr_eff) : (pe_img >= thr_eff);
        px      = vsync_rise ? 10'd0 : x_q;
        py      = vsync_rise ? 10'd0 : y_q;

        x_d = x_q;
        y_d = y_q;
        if (href_fall) begin
            x_d = 10'd0;
            if (y_q != YSat) y_d = y_q + 10'd1;
        end
        if (vsync_rise) begin
            x_d = 10'd0;
            y_d = 10'd0;
        end
        if (pix && (px != XSat)) x_d = px + 10'd1;

        state_d = state_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        cnt_d   = cnt_q;
        publish = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (vsync_rise) state_d = StActive;
            end
            StActive: begin
                if (vsync_fall) begin
                    state_d = StDone;
                    publish = 1'b1;
                end
            end
            StDone: begin
                // Back-to-back frames: a new frame may start on the publish cycle.
                state_d = vsync_rise ? StActive : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (vsync_rise) begin
            xmin_d = 10'h3ff;
            xmax_d = 10'd0;
            ymin_d = 10'h3ff;
            ymax_d = 10'd0;
            cnt_d  = '0;
        end

        if ((state_d == StActive) && pix && fg) begin
            if (px < xmin_d) xmin_d = px;
            if (px > xmax_d) xmax_d = px;
            if (py < ymin_d) ymin_d = py;
            if (py > ymax_d) ymax_d = py;
            if (cnt_d != CntSat) cnt_d = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Treat vsync as already high so a release mid-frame does not fake a rising edge.
            vsync_q         <= 1'b1;
            href_q          <= 1'b0;
            thr_q           <= 8'd0;
            x_q             <= 10'd0;
            y_q             <= 10'd0;
            state_q         <= StIdle;
            xmin_q          <= 10'd0;
            xmax_q          <= 10'd0;
            ymin_q          <= 10'd0;
            ymax_q          <= 10'd0;
            cnt_q           <= '0;
            pos_frame_vsync <= 1'b0;
            pos_frame_href  <= 1'b0;
            pos_frame_clken <= 1'b0;
            pos_img         <= 8'd0;
            frame_done      <= 1'b0;
            bbox_valid      <= 1'b0;
            x_min           <= 10'd0;
            x_max           <= 10'd0;
            y_min           <= 10'd0;
            y_max           <= 10'd0;
            fg_count        <= '0;
        end else begin
            vsync_q         <= pe_frame_vsync;
            href_q          <= pe_frame_href;
            thr_q           <= thr_d;
            x_q             <= x_d;
            y_q             <= y_d;
            state_q         <= state_d;
            xmin_q          <= xmin_d;
            xmax_q          <= xmax_d;
            ymin_q          <= ymin_d;
            ymax_q          <= ymax_d;
            cnt_q           <= cnt_d;
            pos_frame_vsync <= pe_frame_vsync;
            pos_frame_href  <= pe_frame_href;
            pos_frame_clken <= pe_frame_clken;
            pos_img         <= (pe_frame_href && fg) ? 8'd255 : 8'd0;
            frame_done      <= publish;
            if (publish) begin
                bbox_valid <= (cnt_q != '0);
                if (cnt_q != '0) begin
                    x_min    <= xmin_q;
                    x_max    <= xmax_q;
                    y_min    <= ymin_q;
                    y_max    <= ymax_q;
                    fg_count <= cnt_q;
                end else begin
                    x_min    <= 10'd0;
                    x_max    <= 10'd0;
                    y_min    <= 10'd0;
                    y_max    <= 10'd0;
                    fg_count <= '0;
                end
            end
        end
    end

endmodule
